collision_score: RTL and testbench

COLLISION_SCORE -- requirements
Module: collision_score

---
 rtl/flappy_pkg.sv | 30 +++
 rtl/collision_score_if.sv | 24 ++
 rtl/bar_hit_check.sv | 30 +++
 rtl/collision_score.sv | 110 +++++++++++
 tb/tb_collision_score.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared game constants and types for the bar generators, renderer and collision/score block.
package flappy_pkg;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BIRD_X    = 160;
  localparam int BIRD_SIZE = 16;
  localparam int BAR_WIDTH = 40;
  localparam int GAP_HALF  = 60;
  localparam int GROUND_Y  = 479;
  localparam int SCORE_MAX = 999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    LOST = 2'd2
  } state_t;

  typedef struct packed {
    logic overlap;
    logic safe;
    logic passed;
  } bar_stat_t;

  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [1:0] inc,
                                         input logic [9:0] lim);
    logic [10:0] s;
    s = {1'b0, a} + {9'b0, inc};
    return (s > {1'b0, lim}) ? lim : s[9:0];
  endfunction
endpackage

// File: rtl/collision_score_if.sv
// Game-state bus between the bird/bar sources and the collision/score block.
interface collision_score_if;
  import flappy_pkg::*;

  logic       game_start;
  logic       restart;
  logic [9:0] bird_y;
  logic [9:0] x_bar0, x_bar1;
  logic [8:0] y_gap0, y_gap1;
  logic       wraps0, wraps1;
  logic       lose;
  logic [9:0] score;
  logic [9:0] high_score;
  state_t     state;

  modport master (
    output game_start, restart, bird_y, x_bar0, x_bar1, y_gap0, y_gap1, wraps0, wraps1,
    input  lose, score, high_score, state
  );
  modport slave (
    input  game_start, restart, bird_y, x_bar0, x_bar1, y_gap0, y_gap1, wraps0, wraps1,
    output lose, score, high_score, state
  );
endinterface

// File: rtl/bar_hit_check.sv
// Geometry of one bar against the bird: horizontal overlap, bird inside gap, bar already passed.
module bar_hit_check #(
  parameter int BIRD_X    = flappy_pkg::BIRD_X,
  parameter int BIRD_SIZE = flappy_pkg::BIRD_SIZE,
  parameter int BAR_WIDTH = flappy_pkg::BAR_WIDTH,
  parameter int GAP_HALF  = flappy_pkg::GAP_HALF
) (
  input  logic                  [9:0] bird_y,
  input  logic                  [9:0] x_bar,
  input  logic                  [8:0] y_gap,
  output flappy_pkg::bar_stat_t       stat
);
  import flappy_pkg::*;

  logic        [10:0] xl, xr;
  logic signed [11:0] by_top, by_bot, gap_lo, gap_hi;

  // Widened by one bit so bars near x=1023 never wrap; gap math signed so a low gap can't underflow.
  always_comb begin
    xl           = {1'b0, x_bar};
    xr           = xl + 11'(BAR_WIDTH - 1);
    by_top       = $signed({2'b00, bird_y});
    by_bot       = by_top + $signed(12'(BIRD_SIZE - 1));
    gap_lo       = $signed({3'b000, y_gap}) - $signed(12'(GAP_HALF));
    gap_hi       = $signed({3'b000, y_gap}) + $signed(12'(GAP_HALF));
    stat.overlap = (xl <= 11'(BIRD_X + BIRD_SIZE - 1)) && (xr >= 11'(BIRD_X));
    stat.safe    = (by_top >= gap_lo) && (by_bot <= gap_hi);
    stat.passed  = xr < 11'(BIRD_X);
  end
endmodule

// File: rtl/collision_score.sv
// Game FSM: registers bird/bar collisions into LOST, counts passed bars, tracks the high score.
module collision_score #(
  parameter int BIRD_X    = flappy_pkg::BIRD_X,
  parameter int BIRD_SIZE = flappy_pkg::BIRD_SIZE,
  parameter int BAR_WIDTH = flappy_pkg::BAR_WIDTH,
  parameter int GAP_HALF  = flappy_pkg::GAP_HALF,
  parameter int GROUND_Y  = flappy_pkg::GROUND_Y,
  parameter int SCORE_MAX = flappy_pkg::SCORE_MAX
) (
  input logic              clk_25MHz,
  input logic              reset_n,
  collision_score_if.slave bus
);
  import flappy_pkg::*;

  localparam int NUM_BARS = 2;

  logic      [NUM_BARS-1:0][9:0] x_bar_v;
  logic      [NUM_BARS-1:0][8:0] y_gap_v;
  logic      [NUM_BARS-1:0]      wraps_v;
  bar_stat_t [NUM_BARS-1:0]      stat;

  assign x_bar_v = {bus.x_bar1, bus.x_bar0};
  assign y_gap_v = {bus.y_gap1, bus.y_gap0};
  assign wraps_v = {bus.wraps1, bus.wraps0};

  for (genvar i = 0; i < NUM_BARS; i++) begin : g_bar
    bar_hit_check #(
      .BIRD_X   (BIRD_X),
      .BIRD_SIZE(BIRD_SIZE),
      .BAR_WIDTH(BAR_WIDTH),
      .GAP_HALF (GAP_HALF)
    ) u_chk (
      .bird_y(bus.bird_y),
      .x_bar (x_bar_v[i]),
      .y_gap (y_gap_v[i]),
      .stat  (stat[i])
    );
  end

  state_t              state_q, state_d;
  logic                hit_q;
  logic [NUM_BARS-1:0] armed_q, armed_d, passed_q, scored;
  logic [9:0]          score_q, score_d, high_q, high_d;
  logic                collision, play_run, count_en, start_game;
  logic [1:0]          inc;

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A cleared game_start in PLAY freezes everything, including the move to LOST.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.game_start)           state_d = PLAY;
      PLAY:    if (bus.game_start && hit_q)  state_d = LOST;
      LOST:    if (bus.restart)              state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  always_comb begin
    collision = ({1'b0, bus.bird_y} + 11'(BIRD_SIZE - 1)) >= 11'(GROUND_Y);
    for (int i = 0; i < NUM_BARS; i++)
      collision = collision | (stat[i].overlap & ~stat[i].safe);
  end

  // A pending hit suppresses scoring in the cycle it ends the game.
  always_comb begin
    play_run   = (state_q == PLAY) && bus.game_start;
    count_en   = play_run && !hit_q;
    start_game = (state_q == IDLE) && (state_d == PLAY);
    inc        = '0;
    for (int i = 0; i < NUM_BARS; i++) begin
      scored[i]  = stat[i].passed & ~passed_q[i] & armed_q[i] & count_en;
      inc        = inc + {1'b0, scored[i]};
      armed_d[i] = armed_q[i];
      if (wraps_v[i] || start_game) armed_d[i] = 1'b1;
      else if (scored[i])           armed_d[i] = 1'b0;
    end
    score_d = score_q;
    if ((state_q == LOST) && (state_d == IDLE)) score_d = '0;
    else if (|scored)                           score_d = sat_add(score_q, inc, 10'(SCORE_MAX));
    high_d = high_q;
    if ((state_q == PLAY) && (state_d == LOST) && (score_q > high_q)) high_d = score_q;
  end

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      hit_q    <= 1'b0;
      armed_q  <= '1;
      passed_q <= '0;
      score_q  <= '0;
      high_q   <= '0;
    end else begin
      hit_q    <= play_run & collision;
      armed_q  <= armed_d;
      for (int i = 0; i < NUM_BARS; i++) passed_q[i] <= stat[i].passed;
      score_q  <= score_d;
      high_q   <= high_d;
    end
  end

  assign bus.lose       = (state_q == LOST);
  assign bus.score      = score_q;
  assign bus.high_score = high_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_collision_score.sv
// Directed bench for collision_score: scoring, hits, ground, saturation, restart and async reset.
module tb_collision_score;
  import flappy_pkg::*;

  logic clk_25MHz = 1'b0;
  logic reset_n   = 1'b0;
  int   n_chk     = 0;
  int   n_fail    = 0;

  collision_score_if bus ();

  collision_score u_dut (
    .clk_25MHz(clk_25MHz),
    .reset_n  (reset_n),
    .bus      (bus.slave)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25MHz);
    #1;
  endtask

  // Rearm both bars at the right edge, then move both past the bird in the same cycle.
  task automatic round();
    bus.x_bar0 = 10'd600; bus.x_bar1 = 10'd600;
    bus.wraps0 = 1'b1;    bus.wraps1 = 1'b1;
    tick();
    bus.wraps0 = 1'b0;    bus.wraps1 = 1'b0;
    bus.x_bar0 = 10'd120; bus.x_bar1 = 10'd120;
    tick();
  endtask

  task automatic restart_pulse();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
  endtask

  initial begin
    bus.game_start = 1'b0; bus.restart = 1'b0;
    bus.bird_y = 10'd200;
    bus.x_bar0 = 10'd600;  bus.x_bar1 = 10'd600;
    bus.y_gap0 = 9'd240;   bus.y_gap1 = 9'd240;
    bus.wraps0 = 1'b0;     bus.wraps1 = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_lose", 32'(bus.lose), 0);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_high", 32'(bus.high_score), 0);
    reset_n = 1'b1;
    tick();
    chk("idle_hold", 32'(bus.state), 0);
    bus.game_start = 1'b1;
    tick();
    chk("start_play", 32'(bus.state), 1);

    // Game 1: single passes, disarm, rearm by wraps, ground boundary.
    bus.x_bar0 = 10'd121; tick();
    chk("pass_121", 32'(bus.score), 0);
    bus.x_bar0 = 10'd120; tick();
    chk("pass_120", 32'(bus.score), 1);
    tick();
    chk("pass_held", 32'(bus.score), 1);
    bus.x_bar0 = 10'd600; tick();
    bus.x_bar0 = 10'd120; tick();
    chk("disarmed", 32'(bus.score), 1);
    bus.x_bar0 = 10'd600; bus.wraps0 = 1'b1; tick();
    bus.wraps0 = 1'b0; bus.x_bar0 = 10'd120; tick();
    chk("rearmed", 32'(bus.score), 2);
    bus.x_bar1 = 10'd120; tick();
    chk("bar1_pass", 32'(bus.score), 3);
    bus.bird_y = 10'd463; tick(); tick();
    chk("ground_463", 32'(bus.lose), 0);
    bus.game_start = 1'b0; bus.bird_y = 10'd464; tick(); tick();
    chk("freeze_state", 32'(bus.state), 1);
    bus.game_start = 1'b1; tick();
    chk("ground_1clk", 32'(bus.lose), 0);
    tick();
    chk("ground_2clk", 32'(bus.lose), 1);
    chk("ground_state", 32'(bus.state), 2);
    chk("ground_high", 32'(bus.high_score), 3);
    bus.bird_y = 10'd200;
    bus.game_start = 1'b0;
    restart_pulse();
    chk("rs1_state", 32'(bus.state), 0);
    chk("rs1_score", 32'(bus.score), 0);
    chk("rs1_high", 32'(bus.high_score), 3);

    // Game 2: reach 5, hit with a simultaneous pass edge.
    bus.game_start = 1'b1; tick();
    restart_pulse();
    chk("restart_play", 32'(bus.state), 1);
    round();
    chk("both_pass", 32'(bus.score), 2);
    round();
    chk("both_pass2", 32'(bus.score), 4);
    bus.x_bar0 = 10'd600; bus.x_bar1 = 10'd600;
    bus.wraps0 = 1'b1; bus.wraps1 = 1'b1; tick();
    bus.wraps0 = 1'b0; bus.wraps1 = 1'b0;
    bus.x_bar0 = 10'd120; tick();
    chk("score5", 32'(bus.score), 5);
    bus.bird_y = 10'd100; bus.x_bar0 = 10'd150; tick();
    chk("hit_1clk", 32'(bus.lose), 0);
    bus.x_bar1 = 10'd120; tick();
    chk("hit_2clk", 32'(bus.lose), 1);
    chk("hit_state", 32'(bus.state), 2);
    chk("hit_wins", 32'(bus.score), 5);
    chk("hit_high", 32'(bus.high_score), 5);
    bus.game_start = 1'b0; bus.bird_y = 10'd200;
    restart_pulse();
    chk("rs2_score", 32'(bus.score), 0);
    chk("rs2_high", 32'(bus.high_score), 5);

    // Game 3: saturate at 999.
    bus.game_start = 1'b1; tick();
    for (int r = 0; r < 499; r++) round();
    chk("score998", 32'(bus.score), 998);
    round();
    chk("sat_999", 32'(bus.score), 999);
    round();
    chk("sat_hold", 32'(bus.score), 999);
    bus.bird_y = 10'd464; tick(); tick();
    chk("sat_high", 32'(bus.high_score), 999);
    bus.bird_y = 10'd200; bus.game_start = 1'b0;
    restart_pulse();

    // Game 4: async reset mid-game, no clock edge in between.
    bus.game_start = 1'b1; tick();
    round(); round();
    chk("score4", 32'(bus.score), 4);
    #5 reset_n = 1'b0;
    #1;
    chk("arst_score", 32'(bus.score), 0);
    chk("arst_lose", 32'(bus.lose), 0);
    chk("arst_state", 32'(bus.state), 0);
    chk("arst_high", 32'(bus.high_score), 0);
    #5 reset_n = 1'b1;
    tick();
    chk("post_rst_play", 32'(bus.state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
